ahb_to_apb_bridge: RTL

Single-clock AHB-Lite to APB4 bridge: the initiator end of the peripheral APB segment. Accepts one AHB-Lite transfer at a time, runs a full APB SETUP/ACCESS sequence, and returns registered read data and the response to AHB. Its PSEL/PADDR feed the APB slave multiplexer, which decodes PADDR[15:12] into per-peripheral selects and returns the merged PREADY/PRDATA/PSLVERR to this block.

---
 rtl/ahb_to_apb_bridge.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite to APB4 bridge: one AHB transfer at a time, converted into a full
// APB SETUP/ACCESS sequence. HRDATA is registered and the response comes back to AHB.
module ahb_to_apb_bridge #(
  parameter int ADDRWIDTH = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSEL,
  input  logic [ADDRWIDTH-1:0] HADDR,
  input  logic [1:0]           HTRANS,
  input  logic [2:0]           HSIZE,
  input  logic [3:0]           HPROT,
  input  logic                 HWRITE,
  input  logic                 HREADY,
  input  logic [31:0]          HWDATA,
  output logic                 HREADYOUT,
  output logic [31:0]          HRDATA,
  output logic                 HRESP,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic                 PWRITE,
  output logic [31:0]          PWDATA,
  output logic [3:0]           PSTRB,
  output logic [2:0]           PPROT,
  input  logic [31:0]          PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_SETUP, ST_ACCESS, ST_DONE, ST_ERR1, ST_ERR2
  } state_t;

  state_t     state, state_nxt;
  logic       accept;
  logic       addr_load;
  logic [3:0] strb_dec;
  logic       unused_bits;

  assign accept      = HSEL & HTRANS[1] & HREADY;
  // An address phase is only taken in states that drive HREADYOUT high.
  assign addr_load   = accept & HREADYOUT;
  assign unused_bits = ^{HTRANS[0], HPROT[3:2]};

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples values from before the clock edge.
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output is given a default first so that no path through the
  // case statement leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    HREADYOUT = 1'b0;
    HRESP     = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    case (state)
      ST_IDLE: begin
        HREADYOUT = 1'b1;
        if (accept) state_nxt = ST_WAIT;
      end
      ST_WAIT:  state_nxt = ST_SETUP;
      ST_SETUP: begin
        PSEL      = 1'b1;
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) state_nxt = PSLVERR ? ST_ERR1 : ST_DONE;
      end
      ST_DONE: begin
        HREADYOUT = 1'b1;
        state_nxt = accept ? ST_WAIT : ST_IDLE;
      end
      ST_ERR1: begin
        HRESP     = 1'b1;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
        state_nxt = accept ? ST_WAIT : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    strb_dec = 4'b1111;
    if (HSIZE == 3'd0)      strb_dec = 4'b0001 << HADDR[1:0];
    else if (HSIZE == 3'd1) strb_dec = HADDR[1] ? 4'b1100 : 4'b0011;
  end

  // The APB-side fields are loaded once per transfer and otherwise held.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PSTRB  <= '0;
      PPROT  <= '0;
      PWDATA <= '0;
      HRDATA <= '0;
    end else begin
      if (addr_load) begin
        PADDR  <= {HADDR[ADDRWIDTH-1:2], 2'b00};
        PWRITE <= HWRITE;
        PPROT  <= {~HPROT[0], 1'b0, HPROT[1]};
        PSTRB  <= HWRITE ? strb_dec : 4'b0000;
      end
      if (state == ST_WAIT && PWRITE) PWDATA <= HWDATA;
      if (state == ST_ACCESS && PREADY && !PSLVERR && !PWRITE) HRDATA <= PRDATA;
    end
  end

endmodule
